alu_op_sequencer: RTL and testbench

Control-side initiator for the status/result register (SR) of the 8-bit CPU. Accepts instruction bytes over a valid/ready handshake, decodes the ALU opcode, and drives the SR's active-low instruction strobes (ISUMn…ISHRn), the active-low write enable ESRn and the operand bus Dsrin in the strobe → write → hold order the SR requires. Sits between instruction fetch and the SR/ALU datapath.

---
 rtl/cpu8_pkg.sv | 21 ++
 rtl/alu_op_sequencer_if.sv | 15 +
 rtl/alu_op_decode.sv | 25 ++
 rtl/alu_op_sequencer.sv | 100 ++++++++++
 tb/tb_alu_op_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared opcodes, sequencer state encoding and default MUL/DIV wait for the 8-bit CPU.
package cpu8_pkg;
   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_SUM = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_MUL = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam int MULDIV_WAIT_DEF = 4;
   typedef enum logic [2:0] {
      IDLE,
      OPERAND,
      SETUP,
`ifdef ALU_MULDIV_EN
      EXEC,
`endif
      WRITE,
      HOLD
   } state_t;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: instruction handshake plus the SR strobe/write/operand bus.
interface alu_op_sequencer_if;
   logic       instr_valid;
   logic [7:0] instr;
   logic       instr_ready;
   logic       busy;
   logic       err;
   logic       isumn, isubn, imuln, idivn, ishln, ishrn;
   logic       esrn;
   logic [7:0] dsrin;
   modport master (output instr_valid, instr,
                   input  instr_ready, busy, err, isumn, isubn, imuln, idivn, ishln, ishrn, esrn, dsrin);
   modport slave  (input  instr_valid, instr,
                   output instr_ready, busy, err, isumn, isubn, imuln, idivn, ishln, ishrn, esrn, dsrin);
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode byte to legal/two-byte/muldiv flags and active-low strobe vector.
// MUL/DIV are legal only when ALU_MULDIV_EN is defined.
module alu_op_decode
   import cpu8_pkg::*;
(
   input  logic [7:0] op,
   output logic       legal,
   output logic       two_byte,
   output logic [5:0] strb
`ifdef ALU_MULDIV_EN
  ,output logic       muldiv
`endif
);
   logic [2:0] f;
   assign f = op[2:0];
`ifdef ALU_MULDIV_EN
   assign legal  = op[7:3] == 5'd0 && f != 3'b111;
   assign muldiv = f == OP_MUL || f == OP_DIV;
`else
   assign legal  = op[7:3] == 5'd0 && f != 3'b111 && f != OP_MUL && f != OP_DIV;
`endif
   assign two_byte = legal && f != OP_NOP;
   // bit 0 = ISUMn ... bit 5 = ISHRn
   assign strb = two_byte ? ~(6'd1 << (f - 3'd1)) : 6'h3f;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts opcode/operand bytes and drives SR strobes, ESRn and Dsrin in strobe->write->hold order.
// Define ALU_MULDIV_EN to enable MUL/DIV with the MULDIV_WAIT execute delay.
module alu_op_sequencer
   import cpu8_pkg::*;
#(
   parameter int MULDIV_WAIT = MULDIV_WAIT_DEF
)(
   input logic clk,
   input logic rst,
   alu_op_sequencer_if.slave bus
);
   logic       legal, two_byte, acc;
   logic [5:0] dec_strb, strb_q, strb;
   logic       ready, busy, err, esrn;
   logic [7:0] dsrin;
   state_t     state;
`ifdef ALU_MULDIV_EN
   logic       muldiv, is_md;
   logic [3:0] cnt;
`endif
   alu_op_decode u_dec (
      .op       (bus.instr),
      .legal    (legal),
      .two_byte (two_byte),
`ifdef ALU_MULDIV_EN
      .muldiv   (muldiv),
`endif
      .strb     (dec_strb)
   );
   assign acc = bus.instr_valid & ready;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         strb_q <= 6'h3f;
         strb   <= 6'h3f;
         ready  <= 1'b0;
         busy   <= 1'b0;
         err    <= 1'b0;
         esrn   <= 1'b1;
         dsrin  <= 8'h00;
`ifdef ALU_MULDIV_EN
         is_md  <= 1'b0;
         cnt    <= 4'd0;
`endif
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               ready <= 1'b1;
               if (acc && two_byte) begin
                  state  <= OPERAND;
                  strb_q <= dec_strb;
                  busy   <= 1'b1;
`ifdef ALU_MULDIV_EN
                  is_md  <= muldiv;
`endif
               end else if (acc && !legal) err <= 1'b1;
            end
            OPERAND: if (acc) begin
               dsrin <= bus.instr;
               strb  <= strb_q;
               ready <= 1'b0;
               state <= SETUP;
            end
`ifdef ALU_MULDIV_EN
            SETUP: begin
               cnt   <= 4'(MULDIV_WAIT - 1);
               state <= is_md ? EXEC : WRITE;
               esrn  <= is_md;
            end
            EXEC: if (cnt == 4'd0) begin
               state <= WRITE;
               esrn  <= 1'b0;
            end else cnt <= cnt - 4'd1;
`else
            SETUP: begin
               state <= WRITE;
               esrn  <= 1'b0;
            end
`endif
            WRITE: begin
               state <= HOLD;
               esrn  <= 1'b1;
            end
            HOLD: begin
               state <= IDLE;
               strb  <= 6'h3f;
               busy  <= 1'b0;
               ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   assign bus.instr_ready = ready;
   assign bus.busy        = busy;
   assign bus.err         = err;
   assign bus.esrn        = esrn;
   assign bus.dsrin       = dsrin;
   assign {bus.ishrn, bus.ishln, bus.idivn, bus.imuln, bus.isubn, bus.isumn} = strb;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer; MUL path checked when ALU_MULDIV_EN is defined.
module tb_alu_op_sequencer;
   localparam int W = 4;
   typedef struct {
      logic [5:0] strb;
      logic [7:0] d;
      int         len;
      int         esr_at;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   alu_op_sequencer_if bus();
   alu_op_sequencer #(.MULDIV_WAIT(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   function automatic logic [5:0] strobes();
      return {bus.ishrn, bus.ishln, bus.idivn, bus.imuln, bus.isubn, bus.isumn};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b, input bit hold);
      bus.instr_valid = 1'b1;
      bus.instr       = b;
      for (int i = 0; i < 50 && bus.instr_ready !== 1'b1; i++) tick();
      n_cmp++;
      if (bus.instr_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL send %h: instr_ready=%b required 1", b, bus.instr_ready);
      end
      tick();
      if (!hold) bus.instr_valid = 1'b0;
   endtask
   // expected strobe pattern and timing derived from the opcode alone
   task automatic expect_op(input int k, input logic [7:0] d);
      exp_t e;
      e.strb      = 6'h3f;
      e.strb[k-1] = 1'b0;
      e.d         = d;
      e.len       = (k == 3 || k == 4) ? 3 + W : 3;
      e.esr_at    = e.len - 2;
      exp_q.push_back(e);
   endtask
   task automatic observe(input string name);
      exp_t e;
      e = exp_q.pop_front();
      for (int i = 0; i < e.len; i++) begin
         n_cmp++;
         if (strobes() !== e.strb || bus.esrn !== 1'(i != e.esr_at) || bus.dsrin !== e.d ||
             bus.instr_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s cyc %0d: strb=%b esrn=%b d=%h rdy=%b busy=%b required strb=%b esrn=%b d=%h rdy=0 busy=1",
                     name, i, strobes(), bus.esrn, bus.dsrin, bus.instr_ready, bus.busy,
                     e.strb, 1'(i != e.esr_at), e.d);
         end
         tick();
      end
      n_cmp++;
      if (strobes() !== 6'h3f || bus.esrn !== 1'b1 || bus.instr_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s end: strb=%b esrn=%b rdy=%b busy=%b required 111111/1/1/0",
                  name, strobes(), bus.esrn, bus.instr_ready, bus.busy);
      end
   endtask
   task automatic check_idle(input string name, input logic err_exp);
      n_cmp++;
      if (bus.err !== err_exp || strobes() !== 6'h3f || bus.esrn !== 1'b1 ||
          bus.instr_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s: err=%b strb=%b esrn=%b rdy=%b busy=%b required err=%b 111111/1/1/0",
                  name, bus.err, strobes(), bus.esrn, bus.instr_ready, bus.busy, err_exp);
      end
   endtask
   task automatic test_reset();
      bus.instr_valid = 1'b0;
      bus.instr       = 8'h00;
      rst             = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if (bus.instr_ready !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || strobes() !== 6'h3f ||
          bus.esrn !== 1'b1 || bus.dsrin !== 8'h00) begin
         n_bad++;
         $display("FAIL reset: rdy=%b busy=%b err=%b strb=%b esrn=%b d=%h required 0/0/0/111111/1/00",
                  bus.instr_ready, bus.busy, bus.err, strobes(), bus.esrn, bus.dsrin);
      end
      @(negedge clk) rst = 1'b0;
      tick();
      check_idle("reset release", 1'b0);
   endtask
   task automatic test_sum();
      expect_op(1, 8'h07);
      send(8'h01, 1'b0);
      send(8'h07, 1'b0);
      observe("sum");
   endtask
   task automatic test_sub_valid_held();
      expect_op(2, 8'h04);
      send(8'h02, 1'b1);
      send(8'h04, 1'b1);
      bus.instr = 8'h01;
      observe("sub held");
      bus.instr_valid = 1'b0;
      tick();
      check_idle("sub no extra byte", 1'b0);
   endtask
   task automatic test_muldiv();
`ifdef ALU_MULDIV_EN
      expect_op(3, 8'h09);
      send(8'h03, 1'b0);
      send(8'h09, 1'b0);
      observe("mul");
`else
      send(8'h03, 1'b0);
      check_idle("mul disabled err", 1'b1);
      tick();
      check_idle("mul disabled after", 1'b0);
`endif
   endtask
   task automatic test_illegal();
      logic [7:0] ops[2] = '{8'h07, 8'h21};
      foreach (ops[i]) begin
         send(ops[i], 1'b0);
         check_idle($sformatf("illegal %h err", ops[i]), 1'b1);
         tick();
         check_idle($sformatf("illegal %h after", ops[i]), 1'b0);
      end
      expect_op(6, 8'h55);
      send(8'h06, 1'b0);
      send(8'h55, 1'b0);
      observe("shr after illegal");
   endtask
   task automatic test_nop();
      send(8'h00, 1'b0);
      check_idle("nop", 1'b0);
      tick();
      check_idle("nop after", 1'b0);
   endtask
   task automatic test_back_to_back();
      expect_op(1, 8'h03);
      expect_op(5, 8'h0c);
      send(8'h01, 1'b0);
      send(8'h03, 1'b0);
      observe("b2b first");
      send(8'h05, 1'b0);
      send(8'h0c, 1'b0);
      observe("b2b second");
   endtask
   task automatic test_reset_mid();
      send(8'h05, 1'b0);
      send(8'ha5, 1'b0);
      tick();
      n_cmp++;
      if (bus.ishln !== 1'b0 || bus.esrn !== 1'b0) begin
         n_bad++;
         $display("FAIL shl write: ishln=%b esrn=%b required 0/0", bus.ishln, bus.esrn);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (strobes() !== 6'h3f || bus.esrn !== 1'b1 || bus.instr_ready !== 1'b0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL async reset: strb=%b esrn=%b rdy=%b busy=%b required 111111/1/0/0",
                  strobes(), bus.esrn, bus.instr_ready, bus.busy);
      end
      @(negedge clk) rst = 1'b0;
      tick();
      n_cmp++;
      if (bus.instr_ready !== 1'b1 || bus.dsrin !== 8'h00 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset mid release: rdy=%b d=%h busy=%b required 1/00/0",
                  bus.instr_ready, bus.dsrin, bus.busy);
      end
   endtask
   initial begin
      test_reset();
      test_sum();
      test_sub_valid_held();
      test_muldiv();
      test_illegal();
      test_nop();
      test_back_to_back();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_bad++;
         $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
